neuron_layer_ctrl: RTL and testbench

Sequencer that time-multiplexes one shared 2-input, 4-bit weighted-sum/threshold datapath across a layer of N_NEUR neurons. It holds per-neuron weights and thresholds loaded through a configuration port. It accepts one input sample via a valid/ready handshake, evaluates every neuron in turn, and presents the layer's firing vector with a one-cycle valid strobe. It sits between the sample source and downstream logic, replacing N_NEUR dedicated neuron instances.

---
 rtl/neuron_layer_ctrl.sv | 131 +++++++++++++
 tb/tb_neuron_layer_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_ctrl.sv
// Layer sequencer: one shared 2-input weighted-sum/threshold datapath evaluates
// N_NEUR neurons in turn (MUL1, MUL2, CMP per neuron) for each accepted sample.
module neuron_layer_ctrl #(
    parameter int unsigned N_NEUR = 4,
    parameter int unsigned IDXW   = 2
) (
    input  logic              clock,
    input  logic              res,
    input  logic              cfg_we,
    input  logic [IDXW-1:0]   cfg_idx,
    input  logic [3:0]        cfg_w1,
    input  logic [3:0]        cfg_w2,
    input  logic [3:0]        cfg_t,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        inp1,
    input  logic [3:0]        inp2,
    output logic              out_valid,
    output logic [N_NEUR-1:0] out_fire,
    output logic              busy
);

    typedef enum logic [2:0] {StIdle, StMul1, StMul2, StCmp, StDone} state_e;

    localparam logic [IDXW-1:0] LastIdx = IDXW'(N_NEUR - 1);
    localparam logic [IDXW:0]   NumNeur = (IDXW + 1)'(N_NEUR);

    state_e              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [8:0]          acc_q, acc_d;
    logic [3:0]          in1_q, in1_d, in2_q, in2_d;
    logic [3:0]          w1_q [N_NEUR];
    logic [3:0]          w1_d [N_NEUR];
    logic [3:0]          w2_q [N_NEUR];
    logic [3:0]          w2_d [N_NEUR];
    logic [3:0]          t_q  [N_NEUR];
    logic [3:0]          t_d  [N_NEUR];
    logic                out_valid_q, out_valid_d;
    logic [N_NEUR-1:0]   out_fire_q, out_fire_d;
    logic                cfg_ok;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        t_d         = t_q;
        out_valid_d = out_valid_q;
        out_fire_d  = out_fire_q;

        // Config only lands in IDLE; a write coinciding with acceptance is used by that sample.
        cfg_ok = cfg_we && (state_q == StIdle) && ({1'b0, cfg_idx} < NumNeur);
        if (cfg_ok) begin
            w1_d[cfg_idx] = cfg_w1;
            w2_d[cfg_idx] = cfg_w2;
            t_d[cfg_idx]  = cfg_t;
        end

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    in1_d   = inp1;
                    in2_d   = inp2;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StMul1;
                end
            end
            StMul1: begin
                acc_d   = 9'(in1_q) * 9'(w1_q[idx_q]);
                state_d = StMul2;
            end
            StMul2: begin
                acc_d   = acc_q + 9'(in2_q) * 9'(w2_q[idx_q]);
                state_d = StCmp;
            end
            StCmp: begin
                out_fire_d[idx_q] = (acc_q >= {1'b0, t_q[idx_q], 4'b0000});
                if (idx_q == LastIdx) begin
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StMul1;
                end
            end
            StDone: begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge res) begin
        if (!res) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            out_valid_q <= 1'b0;
            out_fire_q  <= '0;
            for (int i = 0; i < int'(N_NEUR); i++) begin
                w1_q[i] <= '0;
                w2_q[i] <= '0;
                t_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            out_valid_q <= out_valid_d;
            out_fire_q  <= out_fire_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            t_q         <= t_d;
        end
    end

    assign in_ready  = res && (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_fire  = out_fire_q;

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Directed bench for neuron_layer_ctrl (N_NEUR=4): reset, fire/no-fire, threshold
// equality, config-while-busy and back-to-back samples with hand-computed vectors.
module tb_neuron_layer_ctrl;

    logic       clock;
    logic       res;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [3:0] cfg_w1, cfg_w2, cfg_t;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] inp1, inp2;
    logic       out_valid;
    logic [3:0] out_fire;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    neuron_layer_ctrl #(.N_NEUR(4), .IDXW(2)) dut (
        .clock    (clock),
        .res      (res),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_w1   (cfg_w1),
        .cfg_w2   (cfg_w2),
        .cfg_t    (cfg_t),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inp1     (inp1),
        .inp2     (inp2),
        .out_valid(out_valid),
        .out_fire (out_fire),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cfg_write(input logic [1:0] idx, input logic [3:0] w1, input logic [3:0] w2,
                             input logic [3:0] t);
        @(negedge clock);
        cfg_idx = idx; cfg_w1 = w1; cfg_w2 = w2; cfg_t = t; cfg_we = 1'b1;
        @(posedge clock);
        #1 cfg_we = 1'b0;
    endtask

    // Accepts one sample and watches 16 edges; k counts edges after acceptance.
    task automatic run_sample(input logic [3:0] a, input logic [3:0] b, input bit busy_cfg,
                              output logic [3:0] fire, output int first_k, output int pulses);
        fire = 4'bxxxx; first_k = -1; pulses = 0;
        @(negedge clock);
        inp1 = a; inp2 = b; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (out_valid) begin
                pulses++;
                if (first_k < 0) begin
                    first_k = k;
                    fire = out_fire;
                end
            end
            if (busy_cfg && k == 4) begin
                cfg_idx = 2'd3; cfg_w1 = 4'd0; cfg_w2 = 4'd0; cfg_t = 4'd15; cfg_we = 1'b1;
            end
            if (busy_cfg && k == 5) cfg_we = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [3:0] f;
        int fk, np;
        #2;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_checks++;
        if ({busy, out_valid, out_fire} !== 6'b0) begin
            n_fail++; $display("FAIL rst_outputs got %b want 000000", {busy, out_valid, out_fire});
        end
        @(negedge clock);
        res = 1'b1;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
        cfg_write(2'd0, 4'd15, 4'd15, 4'd1);
        @(negedge clock);
        inp1 = 4'd15; inp2 = 4'd15; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        n_checks++;
        if ({busy, out_fire} !== 5'b10001) begin
            n_fail++; $display("FAIL pre_abort got %b want 10001", {busy, out_fire});
        end
        res = 1'b0;
        #1;
        n_checks++;
        if ({busy, out_valid, out_fire, in_ready} !== 7'b0) begin
            n_fail++; $display("FAIL abort_outputs got %b want 0000000",
                               {busy, out_valid, out_fire, in_ready});
        end
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL held_in_ready got %b want 0", in_ready); end
        res = 1'b1;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_in_ready got %b want 1", in_ready); end
        run_sample(4'd0, 4'd0, 1'b0, f, fk, np);
        n_checks++;
        if (f !== 4'b1111) begin n_fail++; $display("FAIL cleared_fire got %b want 1111", f); end
    endtask

    task automatic test_basic_fire;
        logic [3:0] f;
        int fk, np;
        cfg_write(2'd0, 4'd15, 4'd13, 4'd8);
        run_sample(4'd14, 4'd6, 1'b0, f, fk, np);
        n_checks++;
        if (f !== 4'b1111) begin n_fail++; $display("FAIL basic_fire got %b want 1111", f); end
        n_checks++;
        if (fk !== 12) begin n_fail++; $display("FAIL basic_latency got %0d want 12", fk); end
        n_checks++;
        if (np !== 1) begin n_fail++; $display("FAIL basic_pulses got %0d want 1", np); end
    endtask

    task automatic test_no_fire;
        logic [3:0] f;
        int fk, np;
        cfg_write(2'd1, 4'd11, 4'd15, 4'd15);
        run_sample(4'd8, 4'd2, 1'b0, f, fk, np);
        n_checks++;
        if (f !== 4'b1101) begin n_fail++; $display("FAIL no_fire got %b want 1101", f); end
    endtask

    task automatic test_threshold_eq;
        logic [3:0] f;
        int fk, np;
        cfg_write(2'd2, 4'd8, 4'd0, 4'd4);
        run_sample(4'd8, 4'd0, 1'b0, f, fk, np);
        n_checks++;
        if (f !== 4'b1100) begin n_fail++; $display("FAIL thr_equal got %b want 1100", f); end
        run_sample(4'd7, 4'd0, 1'b0, f, fk, np);
        n_checks++;
        if (f !== 4'b1000) begin n_fail++; $display("FAIL thr_below got %b want 1000", f); end
    endtask

    task automatic test_config_busy;
        logic [3:0] f;
        int fk, np;
        run_sample(4'd8, 4'd0, 1'b1, f, fk, np);
        n_checks++;
        if (f !== 4'b1100) begin n_fail++; $display("FAIL busy_cfg_cur got %b want 1100", f); end
        run_sample(4'd8, 4'd0, 1'b0, f, fk, np);
        n_checks++;
        if (f !== 4'b1100) begin n_fail++; $display("FAIL busy_cfg_next got %b want 1100", f); end
    endtask

    task automatic test_back_to_back;
        logic exp_rdy, exp_vld;
        @(negedge clock);
        inp1 = 4'd8; inp2 = 4'd0; in_valid = 1'b1;
        cfg_idx = 2'd3; cfg_w1 = 4'd0; cfg_w2 = 4'd0; cfg_t = 4'd15; cfg_we = 1'b1;
        @(posedge clock);
        #1 cfg_we = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 1) inp1 = 4'd7;
            exp_rdy = (k == 13) || (k == 27);
            exp_vld = (k == 12) || (k == 26);
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL b2b_ready k=%0d got %b want %b", k, in_ready, exp_rdy);
            end
            n_checks++;
            if (out_valid !== exp_vld) begin
                n_fail++; $display("FAIL b2b_valid k=%0d got %b want %b", k, out_valid, exp_vld);
            end
            if (k == 12) begin
                n_checks++;
                if (out_fire !== 4'b0100) begin
                    n_fail++; $display("FAIL b2b_fire1 got %b want 0100", out_fire);
                end
            end
            if (k == 26) begin
                n_checks++;
                if (out_fire !== 4'b0000) begin
                    n_fail++; $display("FAIL b2b_fire2 got %b want 0000", out_fire);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        res = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_w1 = '0; cfg_w2 = '0; cfg_t = '0;
        in_valid = 1'b0; inp1 = '0; inp2 = '0;
        test_reset();
        test_basic_fire();
        test_no_fire();
        test_threshold_eq();
        test_config_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
